// File: rtl/regfile_mp_sb_if.sv
// Bus bundle for regfile_mp_sb: read ports, write ports, busy-mark strobes and
// the busy counter. The master drives addresses, data and strobes; the register
// file (slave) returns registered read data, busy flags and the count.
interface regfile_mp_sb_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NREAD  = 6,
  parameter int NWRITE = 2
);
  logic                     en;
  logic [NREAD*ADDR_W-1:0]  rd_addr;
  logic [NREAD*DATA_W-1:0]  rd_data;
  logic [NREAD-1:0]         rd_busy;
  logic [NWRITE-1:0]        we;
  logic [NWRITE*ADDR_W-1:0] waddr;
  logic [NWRITE*DATA_W-1:0] wdata;
  logic [NWRITE-1:0]        mark;
  logic [NWRITE*ADDR_W-1:0] mark_addr;
  logic [ADDR_W:0]          busy_cnt;

  modport master (
    output en, rd_addr, we, waddr, wdata, mark, mark_addr,
    input  rd_data, rd_busy, busy_cnt
  );

  modport slave (
    input  en, rd_addr, we, waddr, wdata, mark, mark_addr,
    output rd_data, rd_busy, busy_cnt
  );
endinterface

// File: rtl/regfile_mp_sb.sv
// Multi-port register file with write-through bypass and a per-register busy
// scoreboard. Register 0 is hard-wired to zero and never busy. Among write
// ports hitting the same register, the highest index (youngest) wins; a mark
// beats a write to the same register so the new producer stays tracked.
module regfile_mp_sb #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NREAD  = 6,
  parameter int NWRITE = 2
) (
  input logic            clk,
  input logic            rs,
  regfile_mp_sb_if.slave bus
);
  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0]       mem [DEPTH];
  logic [DEPTH-1:0]        busy_q;
  logic [DEPTH-1:0]        busy_d;
  logic [DEPTH-1:0]        wr_hit;
  logic [DATA_W-1:0]       wr_val [DEPTH];
  logic [DEPTH-1:0]        mk_hit;
  logic [ADDR_W:0]         cnt_d;
  logic [ADDR_W-1:0]       rd_a [NREAD];
  logic [NREAD*DATA_W-1:0] rd_data_q;
  logic [NREAD-1:0]        rd_busy_q;
  logic [ADDR_W:0]         busy_cnt_q;

  // Resolve writes and marks per register and compute the next busy vector.
  always_comb begin
    // NOTE: every comb output gets a default before the loops, so no path
    // leaves a variable unassigned and no latch is inferred.
    wr_hit = '0;
    mk_hit = '0;
    busy_d = '0;
    cnt_d  = '0;
    for (int r = 0; r < DEPTH; r++) wr_val[r] = '0;
    for (int r = 1; r < DEPTH; r++) begin
      // NOTE: blocking assignments in ascending port order let a later
      // (younger) port overwrite an earlier one, giving highest-index priority.
      for (int w = 0; w < NWRITE; w++) begin
        if (bus.we[w] && bus.waddr[w*ADDR_W +: ADDR_W] == ADDR_W'(r)) begin
          wr_hit[r] = 1'b1;
          wr_val[r] = bus.wdata[w*DATA_W +: DATA_W];
        end
        if (bus.mark[w] && bus.mark_addr[w*ADDR_W +: ADDR_W] == ADDR_W'(r))
          mk_hit[r] = 1'b1;
      end
      if (mk_hit[r])      busy_d[r] = 1'b1;
      else if (wr_hit[r]) busy_d[r] = 1'b0;
      else                busy_d[r] = busy_q[r];
      cnt_d = cnt_d + (ADDR_W+1)'(busy_d[r]);
    end
  end

  // Split the packed read-address bus into per-port addresses.
  always_comb begin
    for (int i = 0; i < NREAD; i++) rd_a[i] = bus.rd_addr[i*ADDR_W +: ADDR_W];
  end

  // Storage, scoreboard and registered read outputs; all frozen while en=0.
  always_ff @(posedge clk or posedge rs) begin
    if (rs) begin
      // NOTE: the array is built from flops (not RAM) because it must clear
      // asynchronously along with everything else.
      for (int r = 0; r < DEPTH; r++) mem[r] <= '0;
      busy_q     <= '0;
      rd_data_q  <= '0;
      rd_busy_q  <= '0;
      busy_cnt_q <= '0;
    end else if (bus.en) begin
      for (int r = 0; r < DEPTH; r++)
        if (wr_hit[r]) mem[r] <= wr_val[r];
      busy_q     <= busy_d;
      busy_cnt_q <= cnt_d;
      for (int i = 0; i < NREAD; i++) begin
        rd_data_q[i*DATA_W +: DATA_W] <= wr_hit[rd_a[i]] ? wr_val[rd_a[i]] : mem[rd_a[i]];
        rd_busy_q[i] <= busy_d[rd_a[i]];
      end
    end
  end

  assign bus.rd_data  = rd_data_q;
  assign bus.rd_busy  = rd_busy_q;
  assign bus.busy_cnt = busy_cnt_q;
endmodule

// File: tb/tb_regfile_mp_sb.sv
// Testbench for regfile_mp_sb: a vector table of stimulus with hand-derived
// expectations pushed into a scoreboard queue, plus hand-written sequences for
// reset, read-all-zero and asynchronous mid-cycle reset.
module tb_regfile_mp_sb;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int NREAD  = 6;
  localparam int NWRITE = 2;

  typedef struct {
    logic        en;
    logic [1:0]  we;
    logic [4:0]  wa0;
    logic [31:0] wd0;
    logic [4:0]  wa1;
    logic [31:0] wd1;
    logic [1:0]  mk;
    logic [4:0]  ma0;
    logic [4:0]  ma1;
    logic [4:0]  ra;    // read by ports 0..2
    logic [4:0]  rb;    // read by ports 3..5
    logic [31:0] ea;
    logic        eba;
    logic [31:0] eb;
    logic        ebb;
    logic [5:0]  ec;
  } vec_t;

  typedef struct {
    logic [31:0] ea;
    logic        eba;
    logic [31:0] eb;
    logic        ebb;
    logic [5:0]  ec;
  } exp_t;

  logic clk;
  logic rs;
  int   total = 0;
  int   bad   = 0;
  exp_t sb_q[$];
  vec_t vecs[17];

  regfile_mp_sb_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NREAD(NREAD), .NWRITE(NWRITE)) bus ();

  regfile_mp_sb #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NREAD(NREAD), .NWRITE(NWRITE)) dut (
    .clk (clk),
    .rs  (rs),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    bus.en        = v.en;
    bus.we        = v.we;
    bus.waddr     = {v.wa1, v.wa0};
    bus.wdata     = {v.wd1, v.wd0};
    bus.mark      = v.mk;
    bus.mark_addr = {v.ma1, v.ma0};
    for (int i = 0; i < NREAD; i++)
      bus.rd_addr[i*ADDR_W +: ADDR_W] = (i < 3) ? v.ra : v.rb;
  endtask

  // Drive one vector, queue its expectation, clock it and compare.
  task automatic apply(input string tag, input vec_t v);
    exp_t e;
    drive(v);
    sb_q.push_back('{v.ea, v.eba, v.eb, v.ebb, v.ec});
    @(posedge clk);
    #1;
    if (sb_q.size() == 0) begin
      total++;
      bad++;
      $display("FAIL %s: scoreboard empty got 0 expected 1", tag);
    end else begin
      e = sb_q.pop_front();
      for (int i = 0; i < NREAD; i++) begin
        check($sformatf("%s rd_data[%0d]", tag, i), bus.rd_data[i*DATA_W +: DATA_W],
              (i < 3) ? e.ea : e.eb);
        check($sformatf("%s rd_busy[%0d]", tag, i), 32'(bus.rd_busy[i]),
              32'((i < 3) ? e.eba : e.ebb));
      end
      check($sformatf("%s busy_cnt", tag), 32'(bus.busy_cnt), 32'(e.ec));
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " rd_data"}, 32'(bus.rd_data != '0), 32'd0);
    check({tag, " rd_busy"}, 32'(bus.rd_busy), 32'd0);
    check({tag, " busy_cnt"}, 32'(bus.busy_cnt), 32'd0);
  endtask

  function automatic vec_t rd_only(input logic [4:0] ra, input logic [4:0] rb,
                                   input logic [31:0] ea, input logic eba,
                                   input logic [31:0] eb, input logic ebb,
                                   input logic [5:0] ec);
    return '{1'b1, 2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 2'b00, 5'd0, 5'd0,
             ra, rb, ea, eba, eb, ebb, ec};
  endfunction

  initial begin
    //          en    we     wa0   wd0          wa1    wd1          mk     ma0    ma1    ra     rb     ea           eba   eb           ebb   ec
    vecs[0]  = rd_only(5'd0, 5'd31, 32'h0, 1'b0, 32'h0, 1'b0, 6'd0);
    vecs[1]  = '{1'b1, 2'b11, 5'd5, 32'h1111, 5'd5, 32'h2222, 2'b00, 5'd0, 5'd0,
                 5'd5, 5'd0, 32'h2222, 1'b0, 32'h0, 1'b0, 6'd0};
    vecs[2]  = rd_only(5'd5, 5'd5, 32'h2222, 1'b0, 32'h2222, 1'b0, 6'd0);
    vecs[3]  = '{1'b1, 2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 2'b11, 5'd7, 5'd9,
                 5'd7, 5'd9, 32'h0, 1'b1, 32'h0, 1'b1, 6'd2};
    vecs[4]  = '{1'b1, 2'b01, 5'd7, 32'hABCD, 5'd0, 32'h0, 2'b00, 5'd0, 5'd0,
                 5'd7, 5'd9, 32'hABCD, 1'b0, 32'h0, 1'b1, 6'd1};
    vecs[5]  = '{1'b1, 2'b10, 5'd0, 32'h0, 5'd3, 32'h55, 2'b01, 5'd3, 5'd0,
                 5'd3, 5'd7, 32'h55, 1'b1, 32'hABCD, 1'b0, 6'd2};
    vecs[6]  = rd_only(5'd3, 5'd9, 32'h55, 1'b1, 32'h0, 1'b1, 6'd2);
    vecs[7]  = '{1'b1, 2'b11, 5'd0, 32'hFFFF, 5'd0, 32'hFFFF, 2'b11, 5'd0, 5'd0,
                 5'd0, 5'd3, 32'h0, 1'b0, 32'h55, 1'b1, 6'd2};
    vecs[8]  = '{1'b1, 2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 2'b11, 5'd12, 5'd12,
                 5'd12, 5'd3, 32'h0, 1'b1, 32'h55, 1'b1, 6'd3};
    vecs[9]  = '{1'b1, 2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 2'b01, 5'd9, 5'd0,
                 5'd9, 5'd12, 32'h0, 1'b1, 32'h0, 1'b1, 6'd3};
    vecs[10] = '{1'b0, 2'b11, 5'd4, 32'h4444, 5'd5, 32'h5555, 2'b11, 5'd20, 5'd21,
                 5'd4, 5'd5, 32'h0, 1'b1, 32'h0, 1'b1, 6'd3};
    vecs[11] = rd_only(5'd4, 5'd5, 32'h0, 1'b0, 32'h2222, 1'b0, 6'd3);
    vecs[12] = '{1'b1, 2'b11, 5'd20, 32'hA0, 5'd21, 32'hB1, 2'b00, 5'd0, 5'd0,
                 5'd20, 5'd21, 32'hA0, 1'b0, 32'hB1, 1'b0, 6'd3};
    vecs[13] = rd_only(5'd20, 5'd21, 32'hA0, 1'b0, 32'hB1, 1'b0, 6'd3);
    vecs[14] = '{1'b1, 2'b11, 5'd9, 32'h99, 5'd12, 32'hCC, 2'b00, 5'd0, 5'd0,
                 5'd12, 5'd9, 32'hCC, 1'b0, 32'h99, 1'b0, 6'd1};
    vecs[15] = '{1'b1, 2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 2'b11, 5'd1, 5'd31,
                 5'd31, 5'd1, 32'h0, 1'b1, 32'h0, 1'b1, 6'd3};
    vecs[16] = '{1'b1, 2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 2'b01, 5'd2, 5'd0,
                 5'd3, 5'd2, 32'h55, 1'b1, 32'h0, 1'b1, 6'd4};

    // Reset held: everything reads zero before any clock edge.
    rs = 1'b1;
    drive(rd_only(5'd0, 5'd0, 32'h0, 1'b0, 32'h0, 1'b0, 6'd0));
    bus.en = 1'b0;
    #3;
    check_all_zero("in_reset");
    #9;
    rs = 1'b0;

    // Read every address on every port right after reset.
    for (int k = 0; k < 32; k++)
      apply($sformatf("rd_all%0d", k),
            rd_only(5'(k), 5'(31 - k), 32'h0, 1'b0, 32'h0, 1'b0, 6'd0));

    // Table-driven vectors.
    for (int k = 0; k < 17; k++) apply($sformatf("v%0d", k), vecs[k]);

    // Asynchronous reset between edges while four registers are busy.
    #3;
    rs = 1'b1;
    #1;
    check_all_zero("async_rst");
    #2;
    rs = 1'b0;
    apply("post_rst_rd", rd_only(5'd5, 5'd3, 32'h0, 1'b0, 32'h0, 1'b0, 6'd0));
    apply("post_rst_wr", '{1'b1, 2'b10, 5'd0, 32'h0, 5'd6, 32'h66, 2'b00, 5'd0, 5'd0,
                           5'd6, 5'd7, 32'h66, 1'b0, 32'h0, 1'b0, 6'd0});
    apply("post_rst_rd2", rd_only(5'd6, 5'd9, 32'h66, 1'b0, 32'h0, 1'b0, 6'd0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/regfile_mp_sb.md
# regfile_mp_sb

Parametrised multi-port register file with a per-register busy scoreboard for the dual-issue datapath. It provides NREAD registered read ports and NWRITE prioritised write ports with write-through bypass. A busy bit per register marks registers whose producer (for example a pending lw) has issued but not yet written back. It sits between the decoder and the ALU/memory stages and supersedes the fixed 6-read/2-write register bank.

## Interface
- DATA_W, 32, register width
- ADDR_W, 5, register address width; depth = 2**ADDR_W
- NREAD, 6, number of read ports (≥1)
- NWRITE, 2, number of write ports (≥1); higher index = younger instruction
- clk  in  1  clock; all state updates on rising edge
- rs  in  1  reset, asynchronous, active-high
- en  in  1  global enable; 0 freezes all state and outputs
- rd_addr  in  NREAD*ADDR_W  read addresses, port i at [i*ADDR_W +: ADDR_W]
- rd_data  out  NREAD*DATA_W  registered read data, port i at [i*DATA_W +: DATA_W]
- rd_busy  out  NREAD  registered busy flag of the register read on port i
- we  in  NWRITE  write enables
- waddr  in  NWRITE*ADDR_W  write addresses
- wdata  in  NWRITE*DATA_W  write data
- mark  in  NWRITE  set-busy strobes (producer issued)
- mark_addr  in  NWRITE*ADDR_W  registers to mark busy
- busy_cnt  out  ADDR_W+1  number of busy registers, registered

## Operation
- Clock port is `clk`. Reset port is `rs`, asynchronous and active-high. While `rs`=1, all registers, busy bits, `rd_data`, `rd_busy` and `busy_cnt` are 0.
- Register 0:
  - always reads 0 and is never busy;
  - writes and marks to address 0 are ignored.
- Write resolution: if several write ports target the same address in one cycle, the highest-indexed enabled port wins. Lower ports to that address are discarded.
- Read with bypass, per port i, on each enabled edge:
  - if any enabled write targets `rd_addr[i]` (not 0), `rd_data[i]` takes the winning write data;
  - otherwise `rd_data[i]` takes the stored value.
- Scoreboard next state, per register r:
  - set if any `mark` targets r;
  - else cleared if any enabled `we` targets r;
  - else unchanged.
  - Mark wins over write in the same cycle: the write retires the old producer while the mark starts a new one. The write data is still stored and bypassed.
- `rd_busy[i]` is loaded with the next-state busy bit of `rd_addr[i]`, so it is consistent with the bypassed data.
- `busy_cnt` is loaded with the population count of the next-state busy vector. Range 0..2**ADDR_W−1, since register 0 is never busy.
- Duplicate marks of one register in one cycle count once. Marking an already-busy register leaves it busy and does not change the count.
- `en`=0: no writes, no scoreboard change, all outputs hold their last values. Inputs presented while `en`=0 are lost.

## Timing
- Read latency is 1 cycle: address sampled at edge N, data and busy valid after edge N.
- Write latency is 0 for bypass and 1 for storage: a value written at edge N is readable without bypass from edge N+1 onward.
- `busy_cnt` updates at the same edge as the busy bits.
- Reset asserted mid-cycle clears everything immediately, without waiting for `clk`. The first enabled edge after `rs` deasserts behaves as normal operation.
- The block has no handshakes and no stalls; the consumer stalls on `rd_busy`.

## Test plan
- Reset, then read all addresses on all ports → `rd_data`=0, `rd_busy`=0, `busy_cnt`=0.
- Write port 0 {r5 ← 0x1111} and port 1 {r5 ← 0x2222} in one cycle while reading r5 → `rd_data`=0x2222 in that cycle (bypass). A read of r5 the next cycle also returns 0x2222.
- Mark r7 and r9, then read r7 → `rd_busy`=1, `busy_cnt`=2. Write r7=0xABCD → `rd_busy`=0 with data 0xABCD, `busy_cnt`=1.
- In one cycle, write r3=0x55 and mark r3 → r3 stores 0x55, r3 stays busy, and `busy_cnt` increments by 1 only.
- Write r0=0xFFFF and mark r0 → r0 reads 0 and is not busy, `busy_cnt` unchanged. Hold `en`=0 with active writes → no state or output change.
- Assert `rs` asynchronously between edges while 4 registers are busy → all outputs go to 0 immediately; a subsequent read of a previously written register returns 0.
